// File: rtl/hash_table_arbiter_if.sv
// Request, response and hash-table signal bundle for hash_table_arbiter.
// slave is the arbiter's view; master is the requester/table environment's view.
interface hash_table_arbiter_if #(
   parameter int NUM_REQ       = 4,
   parameter int KEY_WIDTH     = 32,
   parameter int VALUE_WIDTH   = 32,
   parameter int CHAINING_SIZE = 4
);
   localparam int CW = (CHAINING_SIZE > 1) ? $clog2(CHAINING_SIZE) : 1;

   logic [NUM_REQ-1:0]             req_valid;
   logic [2*NUM_REQ-1:0]           req_op;
   logic [KEY_WIDTH*NUM_REQ-1:0]   req_key;
   logic [VALUE_WIDTH*NUM_REQ-1:0] req_value;
   logic [NUM_REQ-1:0]             req_ready;
   logic [NUM_REQ-1:0]             rsp_valid;
   logic [VALUE_WIDTH-1:0]         rsp_value;
   logic                           rsp_error;
   logic [CW-1:0]                  rsp_collision;
   logic                           ht_op_en;
   logic [1:0]                     ht_op_sel;
   logic [KEY_WIDTH-1:0]           ht_key;
   logic [VALUE_WIDTH-1:0]         ht_value;
   logic                           ht_op_done;
   logic                           ht_op_error;
   logic [VALUE_WIDTH-1:0]         ht_value_out;
   logic [CW-1:0]                  ht_collision_count;
   logic                           busy;

   modport slave (
      input  req_valid, req_op, req_key, req_value,
      input  ht_op_done, ht_op_error, ht_value_out, ht_collision_count,
      output req_ready, rsp_valid, rsp_value, rsp_error, rsp_collision,
      output ht_op_en, ht_op_sel, ht_key, ht_value, busy
   );

   modport master (
      output req_valid, req_op, req_key, req_value,
      output ht_op_done, ht_op_error, ht_value_out, ht_collision_count,
      input  req_ready, rsp_valid, rsp_value, rsp_error, rsp_collision,
      input  ht_op_en, ht_op_sel, ht_key, ht_value, busy
   );
endinterface

// File: rtl/hash_table_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto a single hash-table port,
// one operation outstanding at a time, with a WAIT timeout and fully registered outputs.
module hash_table_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int KEY_WIDTH      = 32,
   parameter int VALUE_WIDTH    = 32,
   parameter int CHAINING_SIZE  = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic                 clk,
   input logic                 rst_n,
   hash_table_arbiter_if.slave bus
);
   localparam int CW = (CHAINING_SIZE > 1) ? $clog2(CHAINING_SIZE) : 1;
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam logic [1:0] OP_INVALID = 2'b11;

   logic [1:0]             state_q, state_d;
   logic [PW-1:0]          rrPtr_q, rrPtr_d;
   logic [PW-1:0]          grant_q, grant_d;
   logic [1:0]             op_q, op_d;
   logic [KEY_WIDTH-1:0]   key_q, key_d;
   logic [VALUE_WIDTH-1:0] value_q, value_d;
   logic [TW-1:0]          timeout_q, timeout_d;
   logic [NUM_REQ-1:0]     reqReady_q, reqReady_d;
   logic [NUM_REQ-1:0]     rspValid_q, rspValid_d;
   logic [VALUE_WIDTH-1:0] rspValue_q, rspValue_d;
   logic                   rspError_q, rspError_d;
   logic [CW-1:0]          rspColl_q, rspColl_d;
   logic                   htOpEn_q, htOpEn_d;
   logic [1:0]             htOpSel_q, htOpSel_d;
   logic [KEY_WIDTH-1:0]   htKey_q, htKey_d;
   logic [VALUE_WIDTH-1:0] htValue_q, htValue_d;
   logic                   busy_q, busy_d;

   logic                   pickFound;
   logic [PW-1:0]          pickIdx;
   int                     scanIdx;
   logic [TW-1:0]          timeoutInc;

   assign timeoutInc = timeout_q + TW'(1);

   // First valid requester at or after rrPtr_q, wrapping modulo NUM_REQ.
   always_comb begin
      pickFound = 1'b0;
      pickIdx   = '0;
      scanIdx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scanIdx = int'(rrPtr_q) + i;
         if (scanIdx >= NUM_REQ) begin
            scanIdx = scanIdx - NUM_REQ;
         end
         if (!pickFound && bus.req_valid[scanIdx]) begin
            pickFound = 1'b1;
            pickIdx   = scanIdx[PW-1:0];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rrPtr_d    = rrPtr_q;
      grant_d    = grant_q;
      op_d       = op_q;
      key_d      = key_q;
      value_d    = value_q;
      timeout_d  = timeout_q;
      reqReady_d = '0;
      rspValid_d = '0;
      rspValue_d = rspValue_q;
      rspError_d = rspError_q;
      rspColl_d  = rspColl_q;
      htOpEn_d   = 1'b0;
      htOpSel_d  = htOpSel_q;
      htKey_d    = htKey_q;
      htValue_d  = htValue_q;

      case (state_q)
         IDLE: begin
            // A nonzero reqReady_q marks the accept cycle of an already-chosen grant.
            if (reqReady_q != '0) begin
               if (op_q == OP_INVALID) begin
                  state_d             = RESP;
                  rspValid_d[grant_q] = 1'b1;
                  rspValue_d          = '0;
                  rspError_d          = 1'b1;
                  rspColl_d           = '0;
               end else begin
                  state_d   = ISSUE;
                  htOpEn_d  = 1'b1;
                  htOpSel_d = op_q;
                  htKey_d   = key_q;
                  htValue_d = value_q;
               end
            end else if (pickFound) begin
               grant_d             = pickIdx;
               reqReady_d[pickIdx] = 1'b1;
               op_d                = bus.req_op[int'(pickIdx)*2 +: 2];
               key_d               = bus.req_key[int'(pickIdx)*KEY_WIDTH +: KEY_WIDTH];
               value_d             = bus.req_value[int'(pickIdx)*VALUE_WIDTH +: VALUE_WIDTH];
            end
         end
         ISSUE: begin
            state_d   = WAIT;
            timeout_d = '0;
         end
         WAIT: begin
            if (bus.ht_op_done) begin
               state_d             = RESP;
               rspValid_d[grant_q] = 1'b1;
               rspValue_d          = bus.ht_value_out;
               rspError_d          = bus.ht_op_error;
               rspColl_d           = bus.ht_collision_count;
            end else if (timeoutInc == TW'(TIMEOUT_CYCLES)) begin
               state_d             = RESP;
               rspValid_d[grant_q] = 1'b1;
               rspValue_d          = '0;
               rspError_d          = 1'b1;
               rspColl_d           = '0;
               timeout_d           = timeoutInc;
            end else begin
               timeout_d = timeoutInc;
            end
         end
         default: begin
            state_d   = IDLE;
            rrPtr_d   = (grant_q == PW'(NUM_REQ - 1)) ? '0 : grant_q + PW'(1);
            htOpSel_d = '0;
            htKey_d   = '0;
            htValue_d = '0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rrPtr_q    <= '0;
         grant_q    <= '0;
         op_q       <= '0;
         key_q      <= '0;
         value_q    <= '0;
         timeout_q  <= '0;
         reqReady_q <= '0;
         rspValid_q <= '0;
         rspValue_q <= '0;
         rspError_q <= 1'b0;
         rspColl_q  <= '0;
         htOpEn_q   <= 1'b0;
         htOpSel_q  <= '0;
         htKey_q    <= '0;
         htValue_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rrPtr_q    <= rrPtr_d;
         grant_q    <= grant_d;
         op_q       <= op_d;
         key_q      <= key_d;
         value_q    <= value_d;
         timeout_q  <= timeout_d;
         reqReady_q <= reqReady_d;
         rspValid_q <= rspValid_d;
         rspValue_q <= rspValue_d;
         rspError_q <= rspError_d;
         rspColl_q  <= rspColl_d;
         htOpEn_q   <= htOpEn_d;
         htOpSel_q  <= htOpSel_d;
         htKey_q    <= htKey_d;
         htValue_q  <= htValue_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.req_ready     = reqReady_q;
   assign bus.rsp_valid     = rspValid_q;
   assign bus.rsp_value     = rspValue_q;
   assign bus.rsp_error     = rspError_q;
   assign bus.rsp_collision = rspColl_q;
   assign bus.ht_op_en      = htOpEn_q;
   assign bus.ht_op_sel     = htOpSel_q;
   assign bus.ht_key        = htKey_q;
   assign bus.ht_value      = htValue_q;
   assign bus.busy          = busy_q;

endmodule

// File: tb/tb_hash_table_arbiter.sv
// Self-checking bench for hash_table_arbiter: directed vector table, reset/ignore-done
// sequences, and randomized ops checked against a transaction-level round-robin model.
module tb_hash_table_arbiter;
   localparam int NREQ    = 4;
   localparam int KW      = 32;
   localparam int VW      = 32;
   localparam int TIMEOUT = 16;

   logic clk;
   logic rst_n;
   int   checks;
   int   passed;
   int   rrModel;

   hash_table_arbiter_if #(.NUM_REQ(NREQ), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .CHAINING_SIZE(4)) bus ();

   hash_table_arbiter #(
      .NUM_REQ(NREQ), .KEY_WIDTH(KW), .VALUE_WIDTH(VW),
      .CHAINING_SIZE(4), .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  mask;
      logic [7:0]  ops;
      logic [31:0] keyBase;
      logic [31:0] valBase;
      int          delay;
      logic [31:0] dVal;
      logic        dErr;
      logic [1:0]  dColl;
      int          expGrant;
      logic [31:0] expVal;
      logic        expErr;
      logic [1:0]  expColl;
   } vecT;

   vecT vecs[10];

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end else begin
         passed++;
      end
   endtask

   // Transaction-level round robin: first requester at or after rrModel, modulo NREQ.
   function automatic int modelGrant(input logic [3:0] mask, input int rr);
      for (int i = 0; i < NREQ; i++) begin
         if (mask[(rr + i) % NREQ]) return (rr + i) % NREQ;
      end
      return -1;
   endfunction

   // Drives one request set, plays the table side, and checks the whole transaction.
   task automatic applyStimulus(input vecT v);
      int waitCnt;
      logic [3:0] expOh;
      logic [1:0] expOp;
      for (int r = 0; r < NREQ; r++) begin
         bus.req_key[r*KW +: KW]   = v.keyBase ^ (32'(r) << 24);
         bus.req_value[r*VW +: VW] = v.valBase ^ (32'(r) << 20);
      end
      bus.req_op    = v.ops;
      bus.req_valid = v.mask;
      expOh = '0;
      expOh[v.expGrant] = 1'b1;
      expOp = v.ops[2*v.expGrant +: 2];

      waitCnt = 0;
      do begin
         stepCycle();
         waitCnt++;
      end while (bus.req_ready == '0 && waitCnt < 6);
      checkOutput("req_ready", 64'(bus.req_ready), 64'(expOh));
      checkOutput("busy_at_accept", 64'(bus.busy), 64'(0));
      bus.req_valid = '0;

      if (expOp == 2'b11) begin
         stepCycle();
         checkOutput("invalid_no_ht_op_en", 64'(bus.ht_op_en), 64'(0));
      end else begin
         stepCycle();
         checkOutput("ht_op_en", 64'(bus.ht_op_en), 64'(1));
         checkOutput("ht_op_sel", 64'(bus.ht_op_sel), 64'(expOp));
         checkOutput("ht_key", 64'(bus.ht_key), 64'(v.keyBase ^ (32'(v.expGrant) << 24)));
         checkOutput("ht_value", 64'(bus.ht_value), 64'(v.valBase ^ (32'(v.expGrant) << 20)));
         stepCycle();
         checkOutput("ht_op_en_pulse", 64'(bus.ht_op_en), 64'(0));
         if (v.delay > 0) begin
            repeat (v.delay - 1) stepCycle();
            bus.ht_op_done         = 1'b1;
            bus.ht_value_out       = v.dVal;
            bus.ht_op_error        = v.dErr;
            bus.ht_collision_count = v.dColl;
            stepCycle();
            bus.ht_op_done         = 1'b0;
            bus.ht_value_out       = $urandom;
            bus.ht_op_error        = 1'b1;
            bus.ht_collision_count = 2'($urandom);
         end else begin
            repeat (TIMEOUT - 1) stepCycle();
            checkOutput("no_early_timeout", 64'(bus.rsp_valid), 64'(0));
            stepCycle();
         end
      end

      checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(expOh));
      checkOutput("rsp_value", 64'(bus.rsp_value), 64'(v.expVal));
      checkOutput("rsp_error", 64'(bus.rsp_error), 64'(v.expErr));
      checkOutput("rsp_collision", 64'(bus.rsp_collision), 64'(v.expColl));
      checkOutput("busy_in_resp", 64'(bus.busy), 64'(1));
      stepCycle();
      checkOutput("rsp_valid_pulse", 64'(bus.rsp_valid), 64'(0));
      checkOutput("busy_after_resp", 64'(bus.busy), 64'(0));
      checkOutput("rsp_value_hold", 64'(bus.rsp_value), 64'(v.expVal));
      checkOutput("ht_key_idle", 64'(bus.ht_key), 64'(0));
      rrModel = (v.expGrant + 1) % NREQ;
   endtask

   task automatic checkAllZero(input string tag);
      logic [63:0] orAll;
      orAll = 64'(bus.req_ready) | 64'(bus.rsp_valid) | 64'(bus.rsp_value) | 64'(bus.rsp_error)
            | 64'(bus.rsp_collision) | 64'(bus.ht_op_en) | 64'(bus.ht_op_sel) | 64'(bus.ht_key)
            | 64'(bus.ht_value) | 64'(bus.busy);
      checkOutput(tag, orAll, 64'(0));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecT v;
      logic seen;
      checks  = 0;
      passed  = 0;
      rrModel = 0;
      rst_n   = 1'b0;
      bus.req_valid = '0;
      bus.req_op    = '0;
      bus.req_key   = '0;
      bus.req_value = '0;
      bus.ht_op_done         = 1'b0;
      bus.ht_op_error        = 1'b0;
      bus.ht_value_out       = '0;
      bus.ht_collision_count = '0;

      vecs[0] = '{4'b0100, {4{2'b10}}, 32'h0200_0015, 32'h0,         3, 32'hAB, 1'b0, 2'd1, 2, 32'hAB, 1'b0, 2'd1};
      vecs[1] = '{4'b0011, {4{2'b00}}, 32'h0000_1000, 32'hCAFE_0000, 1, 32'h11, 1'b0, 2'd0, 0, 32'h11, 1'b0, 2'd0};
      vecs[2] = '{4'b0011, {4{2'b01}}, 32'h0000_2000, 32'h0,         2, 32'h22, 1'b1, 2'd3, 1, 32'h22, 1'b1, 2'd3};
      vecs[3] = '{4'b0010, {4{2'b11}}, 32'h0000_3000, 32'h0,         1, 32'h33, 1'b0, 2'd2, 1, 32'h0,  1'b1, 2'd0};
      vecs[4] = '{4'b1001, {4{2'b00}}, 32'h0000_4000, 32'hBEEF,      0, 32'h44, 1'b0, 2'd1, 3, 32'h0,  1'b1, 2'd0};
      vecs[5] = '{4'b1111, {4{2'b10}}, 32'h0000_5000, 32'h0,         1, 32'h55, 1'b0, 2'd2, 0, 32'h55, 1'b0, 2'd2};
      vecs[6] = '{4'b1111, {4{2'b00}}, 32'h0000_6000, 32'h600,       1, 32'h66, 1'b0, 2'd1, 1, 32'h66, 1'b0, 2'd1};
      vecs[7] = '{4'b1111, {4{2'b01}}, 32'h0000_7000, 32'h0,         1, 32'h77, 1'b1, 2'd0, 2, 32'h77, 1'b1, 2'd0};
      vecs[8] = '{4'b1111, {4{2'b10}}, 32'h0000_8000, 32'h0,         1, 32'h88, 1'b0, 2'd3, 3, 32'h88, 1'b0, 2'd3};
      vecs[9] = '{4'b1111, {4{2'b00}}, 32'h0000_9000, 32'h900,       1, 32'h99, 1'b0, 2'd1, 0, 32'h99, 1'b0, 2'd1};

      stepCycle();
      stepCycle();
      checkAllZero("reset_outputs");
      rst_n = 1'b1;
      stepCycle();

      // A stray completion while idle must not produce a response.
      bus.ht_op_done = 1'b1;
      stepCycle();
      bus.ht_op_done = 1'b0;
      stepCycle();
      checkAllZero("idle_done_ignored");

      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Reset while waiting on the table, then a late completion after release.
      bus.req_valid = 4'b0100;
      bus.req_op    = {4{2'b10}};
      stepCycle();
      stepCycle();
      bus.req_valid = '0;
      stepCycle();
      stepCycle();
      stepCycle();
      rst_n = 1'b0;
      #1;
      checkAllZero("async_reset_mid_wait");
      stepCycle();
      rst_n = 1'b1;
      bus.ht_op_done = 1'b1;
      stepCycle();
      bus.ht_op_done = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         stepCycle();
         if (bus.rsp_valid != '0 || bus.busy) seen = 1'b1;
      end
      checkOutput("no_rsp_after_reset", 64'(seen), 64'(0));
      rrModel = 0;
      v = '{4'b1111, {4{2'b10}}, 32'h0000_A000, 32'h0, 1, 32'hA5, 1'b0, 2'd2, 0, 32'hA5, 1'b0, 2'd2};
      applyStimulus(v);

      for (int n = 0; n < 40; n++) begin
         v.mask    = 4'($urandom_range(1, 15));
         v.ops     = 8'($urandom);
         v.keyBase = $urandom;
         v.valBase = $urandom;
         v.delay   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
         v.dVal    = $urandom;
         v.dErr    = 1'($urandom);
         v.dColl   = 2'($urandom);
         v.expGrant = modelGrant(v.mask, rrModel);
         if (v.ops[2*v.expGrant +: 2] == 2'b11 || v.delay == 0) begin
            v.expVal  = '0;
            v.expErr  = 1'b1;
            v.expColl = '0;
         end else begin
            v.expVal  = v.dVal;
            v.expErr  = v.dErr;
            v.expColl = v.dColl;
         end
         applyStimulus(v);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
